uart_rx_edge_sampler: RTL and testbench

Oversampling front end of the UART receiver. Counts oversampling edges and bit positions while the RX FSM holds it enabled, captures the RX line around mid-bit, and presents a stable `Sampled_Bit`. Sits directly upstream of the deserializer, parity-check and stop-check stages, which consume `Sampled_Bit` and `Edge_Cnt` at `Edge_Cnt == (Prescale>>1)+3`.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_edge_sampler_majority3.sv | 11 +
 rtl/uart_rx_edge_sampler.sv | 113 +++++++++++
 tb/tb_uart_rx_edge_sampler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and types for the UART RX oversampling front end
package uart_rx_pkg;

  localparam int unsigned UART_PRESCALE_8  = 8;
  localparam int unsigned UART_PRESCALE_16 = 16;
  localparam int unsigned UART_PRESCALE_32 = 32;

  localparam int unsigned UART_MAX_FRAME_BITS = 11;

  // Sample window offsets relative to H = Prescale >> 1 (shared with deserializer/checkers)
  localparam int unsigned SMP_OPEN_OFS         = 1;  // first capture and Sample_Valid clear at H-1
  localparam int unsigned SMP_ISSUE_OFS        = 2;  // majority result registered at H+2
  localparam int unsigned SMP_SINGLE_ISSUE_OFS = 1;  // single-sample result registered at H+1
  localparam int unsigned SMP_CONSUME_OFS      = 3;  // downstream reads Sampled_Bit at H+3

  typedef enum logic {
    SMP_IDLE  = 1'b0,
    SMP_COUNT = 1'b1
  } smp_state_t;

endpackage

// File: rtl/uart_rx_edge_sampler_majority3.sv
// rtl/uart_rx_edge_sampler_majority3.sv - three-input majority vote
module majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// rtl/uart_rx_edge_sampler.sv - UART RX oversampling edge/bit counter and mid-bit sampler
// UART_RX_MAJORITY_EN selects three-sample majority; otherwise a single sample at H.
module uart_rx_edge_sampler #(
  parameter int Prescale_Width = 6,
  parameter int Bit_Cnt_Width  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_In,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic                      Enable,
  output logic [Prescale_Width-1:0] Edge_Cnt,
  output logic [Bit_Cnt_Width-1:0]  Bit_Cnt,
  output logic                      Bit_Tick,
  output logic                      Sampled_Bit,
  output logic                      Sample_Valid
);

  import uart_rx_pkg::*;

  smp_state_t                state_q;
  smp_state_t                state_d;
  logic                      count_en;
  logic [Prescale_Width-1:0] half;
  logic [Prescale_Width-1:0] last_edge;
  logic [Prescale_Width-1:0] open_pt;
  logic [Prescale_Width-1:0] mid_pt;
  logic [Prescale_Width-1:0] issue_pt;
  logic                      s1;
  logic                      vote;

  assign half      = Prescale >> 1;
  assign last_edge = Prescale - Prescale_Width'(1);
  assign open_pt   = half - Prescale_Width'(SMP_OPEN_OFS);
  assign mid_pt    = half;
`ifdef UART_RX_MAJORITY_EN
  logic                      s0;
  logic                      s2;
  logic [Prescale_Width-1:0] post_pt;
  assign post_pt   = half + Prescale_Width'(1);
  assign issue_pt  = half + Prescale_Width'(SMP_ISSUE_OFS);

  majority3 u_vote (
    .a (s0),
    .b (s1),
    .c (s2),
    .y (vote)
  );
`else
  assign issue_pt  = half + Prescale_Width'(SMP_SINGLE_ISSUE_OFS);

  majority3 u_vote (
    .a (s1),
    .b (s1),
    .c (s1),
    .y (vote)
  );
`endif

  // The first enabled edge only parks the counters at 0, so Edge_Cnt reads 0 then 1.
  always_comb begin
    state_d = SMP_IDLE;
    case (state_q)
      SMP_IDLE:  if (Enable) state_d = SMP_COUNT;
      SMP_COUNT: if (Enable) state_d = SMP_COUNT;
      default:   state_d = SMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SMP_IDLE;
    else     state_q <= state_d;
  end

  assign count_en = Enable && (state_q == SMP_COUNT);
  assign Bit_Tick = (state_q == SMP_COUNT) && (Edge_Cnt == last_edge);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Edge_Cnt     <= '0;
      Bit_Cnt      <= '0;
      Sample_Valid <= 1'b0;
      Sampled_Bit  <= 1'b1;
      s1           <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      s0           <= 1'b1;
      s2           <= 1'b1;
`endif
    end else if (!count_en) begin
      Edge_Cnt     <= '0;
      Bit_Cnt      <= '0;
      Sample_Valid <= 1'b0;
    end else begin
      if (Edge_Cnt == last_edge) begin
        Edge_Cnt <= '0;
        Bit_Cnt  <= Bit_Cnt + Bit_Cnt_Width'(1);
      end else begin
        Edge_Cnt <= Edge_Cnt + Prescale_Width'(1);
      end
      if (Edge_Cnt == open_pt) Sample_Valid <= 1'b0;
      if (Edge_Cnt == mid_pt)  s1 <= RX_In;
`ifdef UART_RX_MAJORITY_EN
      if (Edge_Cnt == open_pt) s0 <= RX_In;
      if (Edge_Cnt == post_pt) s2 <= RX_In;
`endif
      if (Edge_Cnt == issue_pt) begin
        Sampled_Bit  <= vote;
        Sample_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// tb/tb_uart_rx_edge_sampler.sv - directed self-checking bench for uart_rx_edge_sampler
module tb_uart_rx_edge_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_In;
  logic [5:0] Prescale;
  logic       Enable;
  logic [5:0] Edge_Cnt;
  logic [3:0] Bit_Cnt;
  logic       Bit_Tick;
  logic       Sampled_Bit;
  logic       Sample_Valid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam logic MAJ = 1'b1;
`else
  localparam logic MAJ = 1'b0;
`endif

  uart_rx_edge_sampler #(.Prescale_Width(6), .Bit_Cnt_Width(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_In        (RX_In),
    .Prescale     (Prescale),
    .Enable       (Enable),
    .Edge_Cnt     (Edge_Cnt),
    .Bit_Cnt      (Bit_Cnt),
    .Bit_Tick     (Bit_Tick),
    .Sampled_Bit  (Sampled_Bit),
    .Sample_Valid (Sample_Valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bit at Prescale p with RX_In low for edges lo..hi; checks the sample at H+3.
  task automatic run_bit(input int p, input int lo, input int hi, input logic exp_bit, input string tag);
    Prescale = 6'(p);
    RX_In    = 1'b1;
    Enable   = 1'b1;
    step();
    for (int e = 0; e < p; e++) begin
      if (e == (p >> 1) + 3) begin
        check({tag, "_bit"}, Sampled_Bit, exp_bit);
        check({tag, "_valid"}, Sample_Valid, 1'b1);
      end
      RX_In = (e >= lo && e <= hi) ? 1'b0 : 1'b1;
      step();
    end
    Enable = 1'b0;
    RX_In  = 1'b1;
    step();
  endtask

  logic [9:0] frame;
  logic       bv;

  initial begin
    rst = 1'b1; Enable = 1'b0; RX_In = 1'b1; Prescale = 6'd8;
    #2;
    check("rst_edge", Edge_Cnt, 0);
    check("rst_bit", Bit_Cnt, 0);
    check("rst_tick", Bit_Tick, 0);
    check("rst_sampled", Sampled_Bit, 1);
    check("rst_valid", Sample_Valid, 0);
    step();
    rst = 1'b0;
    step();

    // Prescale 8, constant 0: three full bits
    RX_In = 1'b0; Enable = 1'b1;
    step();
    for (int b = 0; b < 3; b++) begin
      for (int e = 0; e < 8; e++) begin
        check("p8_edge", Edge_Cnt, e);
        check("p8_bitcnt", Bit_Cnt, b);
        check("p8_tick", Bit_Tick, (e == 7) ? 1 : 0);
        if (e == 7) begin
          check("p8_sampled", Sampled_Bit, 0);
          check("p8_valid", Sample_Valid, 1);
        end
        if (e == 4) check("p8_valid_clr", Sample_Valid, 0);
        step();
      end
    end
    check("p8_bitcnt3", Bit_Cnt, 3);
    Enable = 1'b0;
    step();
    check("dis_edge", Edge_Cnt, 0);
    check("dis_bit", Bit_Cnt, 0);
    check("dis_valid", Sample_Valid, 0);
    check("dis_hold", Sampled_Bit, 0);

    // Prescale 16 glitch cases
    run_bit(16, 7, 7, 1'b1, "g_s0");
    run_bit(16, 8, 8, MAJ, "g_s1");
    run_bit(16, 7, 8, 1'b0, "g_s0s1");
    run_bit(16, 8, 9, 1'b0, "g_s1s2");

    // Frame 0x5A at Prescale 32
    frame = {1'b1, 8'h5A, 1'b0};
    Prescale = 6'd32; RX_In = 1'b1; Enable = 1'b1;
    step();
    for (int b = 0; b < 10; b++) begin
      bv = frame[b];
      for (int e = 0; e < 32; e++) begin
        RX_In = bv;
        if (e == 0) check("fr_bitcnt", Bit_Cnt, b);
        if (e == 19 && b >= 1) check("fr_sampled", Sampled_Bit, bv);
        step();
      end
    end
    Enable = 1'b0; RX_In = 1'b1;
    step();

    // Enable dropped at Edge_Cnt 5, Prescale 8
    Prescale = 6'd8; RX_In = 1'b0; Enable = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    check("drop_pre_sampled", Sampled_Bit, 0);
    RX_In = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("drop_edge5", Edge_Cnt, 5);
    Enable = 1'b0;
    step();
    check("drop_edge", Edge_Cnt, 0);
    check("drop_bit", Bit_Cnt, 0);
    check("drop_tick", Bit_Tick, 0);
    check("drop_valid", Sample_Valid, 0);
    check("drop_sampled", Sampled_Bit, 0);

    // Asynchronous reset mid-bit
    RX_In = 1'b0; Enable = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    check("mr_edge7", Edge_Cnt, 7);
    check("mr_valid", Sample_Valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_edge", Edge_Cnt, 0);
    check("mr_bit", Bit_Cnt, 0);
    check("mr_tick", Bit_Tick, 0);
    check("mr_sampled", Sampled_Bit, 1);
    check("mr_valid0", Sample_Valid, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("mr_resume0", Edge_Cnt, 0);
    step();
    check("mr_resume1", Edge_Cnt, 1);
    Enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
